// File: rtl/affine_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : affine_seq_if
//  Purpose  : Bundles the point/result handshakes, coefficients and the
//             multiplier request/response of the affine sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface affine_seq_if #(
    parameter int WIDTH = 16
);
    // Coefficients from the register file, signed Q8.8
    logic [WIDTH-1:0]   m00_i;
    logic [WIDTH-1:0]   m01_i;
    logic [WIDTH-1:0]   m10_i;
    logic [WIDTH-1:0]   m11_i;
    logic [WIDTH-1:0]   tx_i;
    logic [WIDTH-1:0]   ty_i;

    // Input point handshake
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x_i;
    logic [WIDTH-1:0]   y_i;

    // Result handshake
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   x_o;
    logic [WIDTH-1:0]   y_o;
    logic               sat_o;

    // Shared multiplier
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_result;
    logic               mul_done;
    logic               mul_busy;

    // Sequencer side
    modport master (
        input  m00_i, m01_i, m10_i, m11_i, tx_i, ty_i,
        input  in_valid, x_i, y_i,
        output in_ready,
        output out_valid, x_o, y_o, sat_o,
        input  out_ready,
        output mul_start, mul_a, mul_b,
        input  mul_result, mul_done, mul_busy
    );

    // Register file / multiplier side
    modport slave (
        output m00_i, m01_i, m10_i, m11_i, tx_i, ty_i,
        output in_valid, x_i, y_i,
        input  in_ready,
        input  out_valid, x_o, y_o, sat_o,
        output out_ready,
        input  mul_start, mul_a, mul_b,
        output mul_result, mul_done, mul_busy
    );
endinterface
`default_nettype wire

// File: rtl/affine_seq.sv
`default_nettype none
// ============================================================================
//  Module   : affine_seq
//  Purpose  : Sequences four products per point through the shared multiplier
//             and returns the rounded, saturated Q8.8 affine-transformed point.
//  Revision : 1.0  initial release
// ============================================================================
module affine_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    affine_seq_if.master bus
);

    localparam int AW = 2*WIDTH + 2;

    localparam logic signed [AW-1:0] c_HALF =
        {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] c_RMAX =
        {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] c_RMIN =
        {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_OMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_OMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]              r_k;
    logic signed [WIDTH-1:0] r_x, r_y, r_m00, r_m01, r_m10, r_m11, r_ty;
    logic signed [AW-1:0]    r_acc;
    logic [WIDTH-1:0]        r_mul_a, r_mul_b;
    logic [WIDTH-1:0]        r_x_o, r_y_o;
    logic                    r_sat;

    logic                    w_in_ready, w_out_valid, w_mul_start;
    logic                    w_accept, w_done;
    logic [1:0]              w_k_nxt;
    logic [WIDTH-1:0]        w_nxt_a, w_nxt_b;
    logic signed [AW-1:0]    w_prod_ext, w_sum, w_rnd, w_shf;
    logic                    w_clamp_hi, w_clamp_lo;
    logic [WIDTH-1:0]        w_fin;
    logic                    w_unused;

    // Sign-extend a Q8.8 value into the accumulator, aligned to product scale
    function automatic logic signed [AW-1:0] f_scale(input logic signed [WIDTH-1:0] v);
        return {{(AW-WIDTH-FRAC){v[WIDTH-1]}}, v, {FRAC{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_mul_start = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mul_done) begin
                    w_state_nxt = (r_k == 2'd3) ? ST_OUT : ST_ISSUE;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_done   = (r_state == ST_WAIT) && bus.mul_done;
    assign w_k_nxt  = r_k + 2'd1;

    // Operands for the product that follows the current one
    always_comb begin
        w_nxt_a = r_m00;
        w_nxt_b = r_x;
        case (w_k_nxt)
            2'd0: begin w_nxt_a = r_m00; w_nxt_b = r_x; end
            2'd1: begin w_nxt_a = r_m01; w_nxt_b = r_y; end
            2'd2: begin w_nxt_a = r_m10; w_nxt_b = r_x; end
            2'd3: begin w_nxt_a = r_m11; w_nxt_b = r_y; end
            default: begin w_nxt_a = r_m00; w_nxt_b = r_x; end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate, round half toward +inf, saturate
    // ------------------------------------------------------------------
    assign w_prod_ext = {{(AW-2*WIDTH){bus.mul_result[2*WIDTH-1]}}, bus.mul_result};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_rnd      = w_sum + c_HALF;
    assign w_shf      = w_rnd >>> FRAC;
    assign w_clamp_hi = (w_shf > c_RMAX);
    assign w_clamp_lo = (w_shf < c_RMIN);
    assign w_fin      = w_clamp_hi ? c_OMAX :
                        w_clamp_lo ? c_OMIN : w_shf[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= 2'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_m00   <= '0;
            r_m01   <= '0;
            r_m10   <= '0;
            r_m11   <= '0;
            r_ty    <= '0;
            r_acc   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_x_o   <= '0;
            r_y_o   <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x     <= bus.x_i;
                r_y     <= bus.y_i;
                r_m00   <= bus.m00_i;
                r_m01   <= bus.m01_i;
                r_m10   <= bus.m10_i;
                r_m11   <= bus.m11_i;
                r_ty    <= bus.ty_i;
                r_acc   <= f_scale(bus.tx_i);
                r_k     <= 2'd0;
                r_sat   <= 1'b0;
                r_mul_a <= bus.m00_i;
                r_mul_b <= bus.x_i;
            end
            if (w_done) begin
                r_acc <= w_sum;
                if (r_k == 2'd1) begin
                    r_x_o <= w_fin;
                    r_acc <= f_scale(r_ty);
                end
                if (r_k == 2'd3) begin
                    r_y_o <= w_fin;
                end
                // Odd products close an output coordinate
                if (r_k[0]) begin
                    r_sat <= r_sat | w_clamp_hi | w_clamp_lo;
                end
                if (r_k != 2'd3) begin
                    r_k     <= w_k_nxt;
                    r_mul_a <= w_nxt_a;
                    r_mul_b <= w_nxt_b;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.mul_start = w_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.x_o       = r_x_o;
    assign bus.y_o       = r_y_o;
    assign bus.sat_o     = r_sat;

    // Busy is informational; issue never waits on it
    assign w_unused = bus.mul_busy;

endmodule
`default_nettype wire

// File: tb/tb_affine_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_affine_seq
//  Purpose  : Directed self-checking bench for affine_seq with an 18-cycle
//             sequential multiplier model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_affine_seq;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    affine_seq_if #(.WIDTH(WIDTH)) bus ();

    affine_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier model: done 18 cycles after start, product of live operands
    logic [4:0]       r_mcnt = '0;
    logic [WIDTH-1:0] r_a_hold = '0, r_b_hold = '0;
    logic             r_prev_start = 1'b0;
    int               starts = 0;
    int               dbl_starts = 0;
    int               stab_err = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            r_mcnt       <= '0;
            r_prev_start <= 1'b0;
        end else begin
            r_prev_start <= bus.mul_start;
            if (bus.mul_start && r_prev_start) dbl_starts <= dbl_starts + 1;
            if (r_mcnt != 0 && (bus.mul_a != r_a_hold || bus.mul_b != r_b_hold))
                stab_err <= stab_err + 1;
            if (bus.mul_start) begin
                r_mcnt   <= 5'd18;
                r_a_hold <= bus.mul_a;
                r_b_hold <= bus.mul_b;
                starts   <= starts + 1;
            end else if (r_mcnt != 0) begin
                r_mcnt <= r_mcnt - 5'd1;
            end
        end
    end

    assign bus.mul_done   = (r_mcnt == 5'd1);
    assign bus.mul_busy   = (r_mcnt != 5'd0);
    assign bus.mul_result = $signed(bus.mul_a) * $signed(bus.mul_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coef(input logic [15:0] m00, m01, m10, m11, tx, ty, x, y);
        bus.m00_i = m00; bus.m01_i = m01; bus.m10_i = m10; bus.m11_i = m11;
        bus.tx_i  = tx;  bus.ty_i  = ty;  bus.x_i   = x;   bus.y_i   = y;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".mul_start"}, 32'(bus.mul_start), 32'd0);
        check({tag, ".mul_a"},     32'(bus.mul_a),     32'd0);
        check({tag, ".mul_b"},     32'(bus.mul_b),     32'd0);
        check({tag, ".x_o"},       32'(bus.x_o),       32'd0);
        check({tag, ".y_o"},       32'(bus.y_o),       32'd0);
        check({tag, ".sat_o"},     32'(bus.sat_o),     32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (!bus.in_ready && g < 50) begin
            step();
            g++;
        end
        check({tag, ".in_ready_wait"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Run one point through the sequencer and compare against hand-computed results
    task automatic run_point(input string tag, input logic [15:0] ex, ey, input logic esat,
                             input int hold, input bit scramble);
        int s0, e0, lat;
        wait_idle(tag);
        s0 = starts;
        e0 = stab_err;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (scramble && lat == 10) begin
                set_coef(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                         16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end
            step();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd76);
        check({tag, ".x_o"},     32'(bus.x_o),   32'(ex));
        check({tag, ".y_o"},     32'(bus.y_o),   32'(ey));
        check({tag, ".sat_o"},   32'(bus.sat_o), 32'(esat));
        check({tag, ".in_ready_out"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ".hold_x"},     32'(bus.x_o),       32'(ex));
            check({tag, ".hold_y"},     32'(bus.y_o),       32'(ey));
            check({tag, ".hold_sat"},   32'(bus.sat_o),     32'(esat));
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".idle_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".starts"},     32'(starts - s0),   32'd4);
        check({tag, ".op_stable"},  32'(stab_err - e0), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_coef(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;
        step();

        // Identity
        set_coef(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0300, 16'hFD00);
        run_point("ident", 16'h0300, 16'hFD00, 1'b0, 0, 1'b0);

        // 90 degree rotation with translation
        set_coef(16'h0000, 16'hFF00, 16'h0100, 16'h0000, 16'h0080, 16'h0, 16'h0100, 16'h0200);
        run_point("rot90", 16'hFE80, 16'h0100, 1'b0, 0, 1'b0);

        // Rounding half toward +inf
        set_coef(16'h0180, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0);
        run_point("rnd_pos", 16'h0002, 16'h0000, 1'b0, 0, 1'b0);
        set_coef(16'hFE80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0);
        run_point("rnd_neg", 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0);

        // Saturation high, low, then sticky flag cleared on next point
        set_coef(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0);
        run_point("sat_hi", 16'h7FFF, 16'h0000, 1'b1, 0, 1'b0);
        set_coef(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0);
        run_point("sat_lo", 16'h8000, 16'h0000, 1'b1, 0, 1'b0);
        set_coef(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0300, 16'hFD00);
        run_point("sat_clr", 16'h0300, 16'hFD00, 1'b0, 0, 1'b0);

        // General mix with back-pressure and coefficient changes mid-computation
        set_coef(16'h0200, 16'h0080, 16'hFF80, 16'h0100, 16'h0100, 16'hFF00, 16'h0400, 16'h0200);
        run_point("bp_snap", 16'h0A00, 16'hFF00, 1'b0, 10, 1'b1);

        // Reset during the second product
        set_coef(16'h0200, 16'h0080, 16'hFF80, 16'h0100, 16'h0100, 16'hFF00, 16'h0400, 16'h0200);
        wait_idle("rst_mid");
        s0 = starts;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (25) step();
        check("rst_mid.pre_starts", 32'(starts - s0), 32'd2);
        check("rst_mid.pre_ready",  32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset("rst_mid");
        run_point("after_rst", 16'h0A00, 16'hFF00, 1'b0, 0, 1'b0);

        check("no_double_start", 32'(dbl_starts), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
